// File: rtl/au_pkg.sv
// au_pkg: shared types for the arith unit scheduler.
// Op bundle, result type and scheduler state encoding.
package au_pkg;

  localparam int D_S = 16;
  localparam int O_S = 2;

  typedef enum logic {
    OP_U,
    OP_S
  } op_type;

  typedef enum logic [O_S-1:0] {
    Add,
    Sub,
    Mul,
    Div
  } operation;

  typedef logic [D_S-1:0] au_o;

  typedef struct packed {
    logic [D_S-1:0] a_in;
    logic [D_S-1:0] b_in;
    operation       op_code;
    op_type         op_typ;
  } au_ip;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } sched_state_e;

endpackage

// File: rtl/au_sched_if.sv
// au_sched_if: request and response handshakes
// between client blocks and the scheduler.
interface au_sched_if import au_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  au_ip [N_REQ-1:0] req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [ID_W-1:0]  rsp_id;
  au_o              rsp_data;
  logic             rsp_dbz;

  modport master (
    output req_valid, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id,
    input  rsp_data, rsp_dbz
  );

  modport slave (
    input  req_valid, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id,
    output rsp_data, rsp_dbz
  );
endinterface

// File: rtl/au_sched_rr_arbiter.sv
// rr_arbiter: first requester at or after ptr, wrapping.
// Purely combinational; one-hot grant plus index.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any
);
  logic [ID_W:0]   s;
  logic [ID_W-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    s   = '0;
    j   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      s = {1'b0, ptr} + (ID_W+1)'(i);
      if (s >= (ID_W+1)'(N_REQ)) begin
        s = s - (ID_W+1)'(N_REQ);
      end
      j = s[ID_W-1:0];
      if (!any && req[j]) begin
        gnt[j] = 1'b1;
        idx    = j;
        any    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/au_sched.sv
// au_sched: round-robin scheduler for one shared arith unit.
// IDLE grants, ISSUE drives the unit, RESP holds the result.
module au_sched import au_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic        clk,
  input  logic        rst,
  au_sched_if.slave   bus,
  output au_ip        au_req,
  input  au_o         au_rsp,
  output logic        busy,
  output logic [15:0] op_count
);
  sched_state_e     state_q, state_d;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic [ID_W-1:0]  id_q, id_d;
  au_ip             op_q, op_d;
  au_o              data_q, data_d;
  logic             dbz_q, dbz_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  idx;
  logic             any;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .req(bus.req_valid),
    .ptr(rr_q),
    .gnt(gnt),
    .idx(idx),
    .any(any)
  );

  assign bus.rsp_id   = id_q;
  assign bus.rsp_data = data_q;
  assign bus.rsp_dbz  = dbz_q;
  assign busy         = (state_q != IDLE);
  assign op_count     = cnt_q;

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    id_d          = id_q;
    op_d          = op_q;
    data_d        = data_q;
    dbz_d         = dbz_q;
    cnt_d         = cnt_q;
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    au_req        = '0;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          bus.req_ready = rst ? '0 : gnt;
          op_d    = bus.req_op[idx];
          id_d    = idx;
          rr_d    = (idx == ID_W'(N_REQ-1)) ? '0 : idx + 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        au_req = rst ? '0 : op_q;
        // a zero divisor makes au_rsp meaningless, so it is dropped
        if (op_q.op_code == Div && op_q.b_in == '0) begin
          data_d = '0;
          dbz_d  = 1'b1;
        end else begin
          data_d = au_rsp;
          dbz_d  = 1'b0;
        end
        cnt_d   = cnt_q + 16'd1;
        state_d = RESP;
      end
      RESP: begin
        bus.rsp_valid = !rst;
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      op_q    <= '0;
      data_q  <= '0;
      dbz_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      data_q  <= data_d;
      dbz_q   <= dbz_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_au_sched.sv
// tb_au_sched: directed and random ops through au_sched
// with a behavioural arith unit and reference model.
module tb_au_sched;
  import au_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  au_ip        au_req;
  au_o         au_rsp;
  logic        busy;
  logic [15:0] op_count;

  int          total = 0;
  int          bad   = 0;
  int          mptr  = 0;
  int          mcount = 0;
  au_ip        ops [4];
  logic [3:0]  vmask;

  always #5 clk = ~clk;

  au_sched_if #(.N_REQ(4), .ID_W(2)) bus ();

  au_sched #(.N_REQ(4), .ID_W(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .au_req  (au_req),
    .au_rsp  (au_rsp),
    .busy    (busy),
    .op_count(op_count)
  );

  // shared arith unit; garbage on divide by zero
  always_comb begin
    au_rsp = '0;
    case (au_req.op_code)
      Add: au_rsp = au_req.a_in + au_req.b_in;
      Sub: au_rsp = au_req.a_in - au_req.b_in;
      Mul: au_rsp = 16'(au_req.a_in * au_req.b_in);
      Div: begin
        if (au_req.b_in == '0)
          au_rsp = 16'hDEAD;
        else if (au_req.op_typ == OP_S)
          au_rsp = 16'($signed(au_req.a_in) / $signed(au_req.b_in));
        else
          au_rsp = au_req.a_in / au_req.b_in;
      end
      default: au_rsp = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_grant(input logic [3:0] m, input int p);
    for (int k = 0; k < 4; k++) begin
      if (m[(p + k) % 4]) return (p + k) % 4;
    end
    return 0;
  endfunction

  function automatic logic [15:0] ref_res(input au_ip op);
    int a, b, r;
    logic [31:0] rv;
    if (op.op_typ == OP_S) begin
      a = int'($signed(op.a_in));
      b = int'($signed(op.b_in));
    end else begin
      a = int'(op.a_in);
      b = int'(op.b_in);
    end
    case (op.op_code)
      Add: r = a + b;
      Sub: r = a - b;
      Mul: r = a * b;
      default: r = (b == 0) ? 0 : a / b;
    endcase
    rv = r;
    return rv[15:0];
  endfunction

  task automatic txn(input int stall);
    int g;
    au_ip op;
    logic [15:0] ed;
    logic ez;
    bus.req_valid = vmask;
    for (int i = 0; i < 4; i++) bus.req_op[i] = ops[i];
    #1;
    g  = ref_grant(vmask, mptr);
    op = ops[g];
    chk("grant", 64'(bus.req_ready), 64'(4'b0001 << g));
    chk("idle_busy", 64'(busy), 64'd0);
    tick();
    bus.req_valid = '0;
    #1;
    chk("issue_au_req", 64'(au_req), 64'(op));
    chk("issue_ready", 64'(bus.req_ready), 64'd0);
    chk("issue_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    tick();
    mptr = (g + 1) % 4;
    mcount++;
    ed = ref_res(op);
    ez = (op.op_code == Div) && (op.b_in == 16'd0);
    for (int s = 0; s <= stall; s++) begin
      bus.rsp_ready = (s == stall);
      bus.req_valid = vmask;
      #1;
      chk("rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("rsp_id", 64'(bus.rsp_id), 64'(g));
      chk("rsp_data", 64'(bus.rsp_data), 64'(ed));
      chk("rsp_dbz", 64'(bus.rsp_dbz), 64'(ez));
      chk("resp_ready", 64'(bus.req_ready), 64'd0);
      chk("resp_busy", 64'(busy), 64'd1);
      chk("resp_au_req", 64'(au_req), 64'd0);
      chk("op_count", 64'(op_count), 64'(mcount % 65536));
      tick();
    end
    bus.rsp_ready = 1'b0;
    bus.req_valid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    chk("rst_rsp_dbz", 64'(bus.rsp_dbz), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    chk("rst_au_req", 64'(au_req), 64'd0);
    rst = 1'b0;
    bus.req_valid = '0;
    mptr = 0;
    mcount = 0;
  endtask

  function automatic au_ip mk(input logic [15:0] a, input logic [15:0] b,
                               input operation c, input op_type t);
    au_ip o;
    o.a_in = a;
    o.b_in = b;
    o.op_code = c;
    o.op_typ = t;
    return o;
  endfunction

  initial begin
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) ops[i] = mk(16'd0, 16'd0, Add, OP_U);

    do_reset();

    ops[2] = mk(16'd100, 16'd27, Add, OP_U);
    vmask  = 4'b0100;
    txn(0);

    ops[0] = mk(16'd9, 16'd4, Sub, OP_U);
    ops[1] = mk(16'd7, 16'd6, Mul, OP_U);
    ops[3] = mk(16'h8000, 16'h8000, Add, OP_S);
    vmask  = 4'b1011;
    txn(5);

    do_reset();
    ops[0] = mk(16'd1, 16'd2, Add, OP_U);
    ops[1] = mk(16'hFFFD, 16'd5, Mul, OP_S);
    ops[2] = mk(16'd300, 16'd301, Sub, OP_U);
    ops[3] = mk(16'hFF00, 16'h0200, Add, OP_U);
    vmask  = 4'b1111;
    for (int k = 0; k < 5; k++) txn(0);

    ops[0] = mk(16'd50, 16'd0, Div, OP_U);
    vmask  = 4'b0001;
    txn(0);
    ops[0] = mk(16'd50, 16'd7, Div, OP_U);
    txn(0);

    vmask = 4'b0010;
    bus.req_valid = vmask;
    tick();
    bus.req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_count", 64'(op_count), 64'd0);
    for (int k = 0; k < 3; k++) begin
      chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      tick();
    end
    mptr = 0;
    mcount = 0;
    vmask = 4'b1111;
    txn(0);

    for (int n = 0; n < 40; n++) begin
      vmask = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        ops[i].a_in    = 16'($urandom);
        ops[i].b_in    = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
        ops[i].op_code = operation'($urandom_range(0, 3));
        ops[i].op_typ  = op_type'($urandom_range(0, 1));
      end
      if (vmask == 4'b0000) begin
        bus.req_valid = vmask;
        #1;
        chk("none_ready", 64'(bus.req_ready), 64'd0);
        tick();
        chk("none_busy", 64'(busy), 64'd0);
      end else begin
        txn($urandom_range(0, 3));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
